// File: rtl/imem_access_arbiter.sv
// rtl/imem_access_arbiter.sv - two-port round-robin read arbiter in front of the instruction memory
module imem_access_arbiter #(
    parameter int RD_CYCLES  = 1,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  f_req,
    input  logic [ADDR_WIDTH-1:0] f_addr,
    output logic                  f_gnt,
    output logic                  f_valid,
    output logic [DATA_WIDTH-1:0] f_data,
    output logic                  f_err,
    input  logic                  d_req,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    output logic                  d_gnt,
    output logic                  d_valid,
    output logic [DATA_WIDTH-1:0] d_data,
    output logic                  d_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  busy
);

    localparam int CNT_W = (RD_CYCLES > 1) ? $clog2(RD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_CYCLES - 1);
    localparam logic SEL_F = 1'b0;
    localparam logic SEL_D = 1'b1;

    typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  owner_q, owner_d;
    logic                  last_q, last_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  f_gnt_q, f_gnt_d, d_gnt_q, d_gnt_d;
    logic                  f_valid_q, f_valid_d, d_valid_q, d_valid_d;
    logic                  f_err_q, f_err_d, d_err_q, d_err_d;
    logic [DATA_WIDTH-1:0] f_data_q, f_data_d, d_data_q, d_data_d;
    logic                  sel;
    logic [ADDR_WIDTH-1:0] sel_addr;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        last_d     = last_q;
        mem_addr_d = mem_addr_q;
        f_gnt_d    = 1'b0;
        d_gnt_d    = 1'b0;
        f_valid_d  = 1'b0;
        d_valid_d  = 1'b0;
        f_err_d    = 1'b0;
        d_err_d    = 1'b0;
        f_data_d   = f_data_q;
        d_data_d   = d_data_q;
        // On a tie the port that did not win last time gets the grant.
        sel        = (f_req && d_req) ? ~last_q : (d_req ? SEL_D : SEL_F);
        sel_addr   = (sel == SEL_D) ? d_addr : f_addr;

        case (state_q)
            IDLE: begin
                if (f_req || d_req) begin
                    owner_d = sel;
                    last_d  = sel;
                    if (sel == SEL_D) d_gnt_d = 1'b1;
                    else              f_gnt_d = 1'b1;
                    if (sel_addr[1:0] != 2'b00) begin
                        state_d = ERR;
                    end else begin
                        mem_addr_d = sel_addr;
                        cnt_d      = '0;
                        state_d    = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    if (owner_q == SEL_D) begin
                        d_valid_d = 1'b1;
                        d_data_d  = mem_data;
                    end else begin
                        f_valid_d = 1'b1;
                        f_data_d  = mem_data;
                    end
                end
            end
            ERR: begin
                state_d = IDLE;
                if (owner_q == SEL_D) begin
                    d_valid_d = 1'b1;
                    d_err_d   = 1'b1;
                    d_data_d  = '0;
                end else begin
                    f_valid_d = 1'b1;
                    f_err_d   = 1'b1;
                    f_data_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            owner_q    <= SEL_D;
            last_q     <= SEL_D;
            mem_addr_q <= '0;
            f_gnt_q    <= 1'b0;
            d_gnt_q    <= 1'b0;
            f_valid_q  <= 1'b0;
            d_valid_q  <= 1'b0;
            f_err_q    <= 1'b0;
            d_err_q    <= 1'b0;
            f_data_q   <= '0;
            d_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            mem_addr_q <= mem_addr_d;
            f_gnt_q    <= f_gnt_d;
            d_gnt_q    <= d_gnt_d;
            f_valid_q  <= f_valid_d;
            d_valid_q  <= d_valid_d;
            f_err_q    <= f_err_d;
            d_err_q    <= d_err_d;
            f_data_q   <= f_data_d;
            d_data_q   <= d_data_d;
        end
    end

    assign f_gnt    = f_gnt_q;
    assign f_valid  = f_valid_q;
    assign f_data   = f_data_q;
    assign f_err    = f_err_q;
    assign d_gnt    = d_gnt_q;
    assign d_valid  = d_valid_q;
    assign d_data   = d_data_q;
    assign d_err    = d_err_q;
    assign mem_addr = mem_addr_q;
    assign busy     = (state_q != IDLE);

endmodule
